// File: rtl/lii_out_packer.sv
// rtl/lii_out_packer.sv - round-robin packer of kernel streams into tagged PW-wide LII beats
// Optional idle-timeout flush of partial beats: define LII_OUT_FLUSH_EN.
module lii_out_packer #(
  parameter int NOUT         = 2,
  parameter int DW           = 8,
  parameter int PW           = 64,
  parameter int SRC_ID       = 0,
  parameter int DST_BASE     = 0,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic               aclk,
  input  logic               arstn,
  input  logic [NOUT*DW-1:0] s_tdata,
  input  logic [NOUT-1:0]    s_tvalid,
  output logic [NOUT-1:0]    s_tready,
  output logic [PW-1:0]      lii_out_p0_tdata,
  output logic               lii_out_p0_tvalid,
  input  logic               lii_out_p0_tready,
  output logic [7:0]         lii_out_p0_src,
  output logic [7:0]         lii_out_p0_dst,
  output logic [7:0]         lii_out_p0_nlanes,
  output logic               ce
);

  localparam int K  = PW / DW;
  localparam int GW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   g, rr, pick;
  logic            pick_ok;
  logic [CW-1:0]   count;
  logic [PW-1:0]   pack;
  logic            accept, push, pop, full, flush_hit;
  logic [1:0]      occ;
  logic [PW-1:0]   q_data [2];
  logic [7:0]      q_dst  [2];
  logic [7:0]      q_nl   [2];

  // Scan downward so the lowest offset from rr is the one that sticks.
  always_comb begin
    pick    = rr;
    pick_ok = 1'b0;
    for (int i = NOUT - 1; i >= 0; i--) begin
      if (s_tvalid[(int'(rr) + i) % NOUT]) begin
        pick    = GW'((int'(rr) + i) % NOUT);
        pick_ok = 1'b1;
      end
    end
  end

`ifdef LII_OUT_FLUSH_EN
  logic [7:0] flush_cnt;

  always_ff @(posedge aclk) begin
    if (!arstn || state != FILL || accept || count == '0) begin
      flush_cnt <= '0;
    end else begin
      flush_cnt <= flush_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    push      = 1'b0;
    flush_hit = 1'b0;
    s_tready  = '0;
    case (state)
      IDLE: if (pick_ok) state_nx = FILL;
      FILL: begin
        for (int i = 0; i < NOUT; i++) s_tready[i] = (g == GW'(i));
        accept = s_tvalid[g];
`ifdef LII_OUT_FLUSH_EN
        flush_hit = (count != '0) && !s_tvalid[g] && (flush_cnt == 8'(FLUSH_CYCLES - 1));
`endif
        if ((accept && count == CW'(K - 1)) || flush_hit) state_nx = COMMIT;
      end
      COMMIT: begin
        if (!full) begin
          push     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      g     <= '0;
      rr    <= '0;
      count <= '0;
      pack  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            g     <= pick;
            count <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            pack[count*DW +: DW] <= s_tdata[g*DW +: DW];
            count                <= count + CW'(1);
          end
        end
        COMMIT: begin
          if (push) begin
            pack  <= '0;
            count <= '0;
            rr    <= (g == GW'(NOUT - 1)) ? '0 : g + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign full = (occ == 2'd2);
  assign pop  = (occ != 2'd0) && lii_out_p0_tready;

  // Slot 0 is always the head; a pop shifts slot 1 down and a push lands behind what remains.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      occ <= '0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_dst[i]  <= '0;
        q_nl[i]   <= '0;
      end
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        q_data[0] <= q_data[1];
        q_dst[0]  <= q_dst[1];
        q_nl[0]   <= q_nl[1];
        q_data[1] <= '0;
        q_dst[1]  <= '0;
        q_nl[1]   <= '0;
      end
      if (push) begin
        if (occ == 2'd0 || (occ == 2'd1 && pop)) begin
          q_data[0] <= pack;
          q_dst[0]  <= 8'(DST_BASE) + 8'(g);
          q_nl[0]   <= 8'(count);
        end else begin
          q_data[1] <= pack;
          q_dst[1]  <= 8'(DST_BASE) + 8'(g);
          q_nl[1]   <= 8'(count);
        end
      end
    end
  end

  assign lii_out_p0_tvalid = (occ != 2'd0);
  assign lii_out_p0_tdata  = q_data[0];
  assign lii_out_p0_dst    = q_dst[0];
  assign lii_out_p0_nlanes = q_nl[0];
  assign lii_out_p0_src    = 8'(SRC_ID);
  assign ce                = !full;

endmodule

// File: tb/tb_lii_out_packer.sv
// tb/tb_lii_out_packer.sv - directed and randomized checks of lii_out_packer against a per-stream byte-queue model
module tb_lii_out_packer;

  localparam int NOUT = 2;
  localparam int DW   = 8;
  localparam int PW   = 64;
  localparam int K    = PW / DW;
  localparam int SRC  = 8'h3C;
  localparam int DB   = 0;

  logic               aclk = 1'b0;
  logic               arstn = 1'b0;
  logic [NOUT*DW-1:0] s_tdata = '0;
  logic [NOUT-1:0]    s_tvalid = '0;
  logic [NOUT-1:0]    s_tready;
  logic [PW-1:0]      o_tdata;
  logic               o_tvalid;
  logic               o_tready = 1'b0;
  logic [7:0]         o_src, o_dst, o_nl;
  logic               ce;

  lii_out_packer #(
    .NOUT(NOUT), .DW(DW), .PW(PW), .SRC_ID(SRC), .DST_BASE(DB), .FLUSH_CYCLES(16)
  ) dut (
    .aclk(aclk), .arstn(arstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .lii_out_p0_tdata(o_tdata), .lii_out_p0_tvalid(o_tvalid), .lii_out_p0_tready(o_tready),
    .lii_out_p0_src(o_src), .lii_out_p0_dst(o_dst), .lii_out_p0_nlanes(o_nl),
    .ce(ce)
  );

  always #5 aclk = ~aclk;

  // sq: bytes still to offer per stream; acc: bytes accepted but not yet seen in a beat.
  logic [7:0] sq  [NOUT][$];
  logic [7:0] acc [NOUT][$];
  logic [7:0] dst_log [$];
  int prob [NOUT];
  int idle_run [NOUT];
  int tests = 0, fails = 0, cyc = 0, beats = 0;
  int last_acc_cyc = 0, first_tv_cyc = 0, tready_pct = 100;
  int last_nl = 0;
  logic [PW-1:0] last_data = '0;
  logic [7:0] last_dst = '0;
  logic prev_tv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat();
    int s, nl;
    logic short_src;
    logic [PW-1:0] exp;
    s = int'(o_dst) - DB;
    nl = int'(o_nl);
    short_src = 1'b0;
    exp = '0;
    chk("beat_src", 64'(o_src), 64'(SRC));
    chk("beat_nlanes_range", 64'(nl >= 1 && nl <= K), 64'd1);
    chk("beat_dst_range", 64'(s >= 0 && s < NOUT), 64'd1);
    if (s >= 0 && s < NOUT) begin
      for (int i = 0; i < nl && i < K; i++) begin
        if (acc[s].size() > 0) exp[i*DW +: DW] = acc[s].pop_front();
        else short_src = 1'b1;
      end
    end
    chk("beat_has_source_bytes", 64'(short_src), 64'd0);
    chk("beat_data", o_tdata, exp);
    beats++;
    last_nl = nl;
    last_data = o_tdata;
    last_dst = o_dst;
    dst_log.push_back(o_dst);
  endtask

  task automatic cycle();
    logic go;
    @(negedge aclk);
    cyc++;
    for (int g = 0; g < NOUT; g++) begin
      go = (sq[g].size() > 0) && ((idle_run[g] >= 3) || ($urandom_range(99) < prob[g]));
      s_tvalid[g] = go;
      s_tdata[g*DW +: DW] = go ? sq[g][0] : 8'h00;
      idle_run[g] = go ? 0 : idle_run[g] + 1;
    end
    o_tready = ($urandom_range(99) < tready_pct);
    #1;
    for (int g = 0; g < NOUT; g++) begin
      if (s_tvalid[g] && s_tready[g]) begin
        acc[g].push_back(sq[g].pop_front());
        last_acc_cyc = cyc;
      end
    end
    if (o_tvalid && !prev_tv) first_tv_cyc = cyc;
    prev_tv = o_tvalid;
    if (o_tvalid && o_tready) check_beat();
  endtask

  task automatic run_until(input int target, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (beats < target && n < max_cyc) begin
      cycle();
      n++;
    end
    chk(tag, 64'(beats >= target), 64'd1);
  endtask

  initial begin
    int base, start, total;
    for (int g = 0; g < NOUT; g++) begin
      prob[g] = 100;
      idle_run[g] = 0;
    end

    // Reset values
    arstn = 1'b0;
    repeat (3) cycle();
    chk("rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_tdata", o_tdata, 64'd0);
    chk("rst_dst", 64'(o_dst), 64'd0);
    chk("rst_nlanes", 64'(o_nl), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_ce", 64'(ce), 64'd1);
    chk("rst_src", 64'(o_src), 64'(SRC));
    arstn = 1'b1;

    // Single stream, back-to-back bytes
    tready_pct = 100;
    for (int i = 1; i <= 8; i++) sq[0].push_back(8'(i));
    run_until(1, 50, "single_beat_timeout");
    chk("single_data", last_data, 64'h0807060504030201);
    chk("single_dst", 64'(last_dst), 64'd0);
    chk("single_nlanes", 64'(last_nl), 64'd8);
    chk("single_latency", 64'(first_tv_cyc - last_acc_cyc), 64'd2);

    // Both streams continuously valid: strict alternation
    base = dst_log.size();
    for (int i = 0; i < 32; i++) begin
      sq[0].push_back(8'(8'hA0 + i));
      sq[1].push_back(8'(8'hB0 + i));
    end
    run_until(beats + 8, 300, "alt_timeout");
    for (int i = base + 1; i < dst_log.size(); i++)
      chk("alt_rotation", 64'(dst_log[i] != dst_log[i-1]), 64'd1);
    chk("alt_drained", 64'(acc[0].size() + acc[1].size()), 64'd0);

    // Phy stall with three beats offered
    tready_pct = 0;
    start = beats;
    for (int i = 1; i <= 24; i++) sq[0].push_back(8'(i));
    repeat (45) cycle();
    chk("stall_head_data_a", o_tdata, 64'h0807060504030201);
    repeat (15) cycle();
    chk("stall_ce", 64'(ce), 64'd0);
    chk("stall_tvalid", 64'(o_tvalid), 64'd1);
    chk("stall_head_data_b", o_tdata, 64'h0807060504030201);
    chk("stall_head_nlanes", 64'(o_nl), 64'd8);
    chk("stall_commit_hold", 64'(s_tready), 64'd0);
    chk("stall_all_accepted", 64'(sq[0].size()), 64'd0);
    chk("stall_no_pop", 64'(beats - start), 64'd0);
    tready_pct = 100;
    run_until(start + 3, 60, "stall_drain_timeout");
    chk("stall_drain_count", 64'(beats - start), 64'd3);
    chk("stall_drain_model_empty", 64'(acc[0].size()), 64'd0);
    repeat (2) cycle();
    chk("stall_ce_back", 64'(ce), 64'd1);

    // Reset during FILL with one beat queued
    tready_pct = 0;
    for (int i = 0; i < 13; i++) sq[0].push_back(8'($urandom));
    repeat (40) cycle();
    chk("midrst_beat_queued", 64'(o_tvalid), 64'd1);
    chk("midrst_in_fill", 64'(s_tready), 64'd1);
    chk("midrst_lanes_taken", 64'(acc[0].size()), 64'd13);
    arstn = 1'b0;
    cycle();
    chk("midrst_tvalid", 64'(o_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_ce", 64'(ce), 64'd1);
    arstn = 1'b1;
    for (int g = 0; g < NOUT; g++) acc[g].delete();
    tready_pct = 100;
    for (int i = 0; i < 8; i++) sq[0].push_back(8'($urandom));
    run_until(beats + 1, 50, "midrst_fresh_timeout");
    chk("midrst_fresh_nlanes", 64'(last_nl), 64'd8);
    chk("midrst_fresh_dst", 64'(last_dst), 64'd0);

`ifdef LII_OUT_FLUSH_EN
    // Idle timeout flushes a partial beat
    start = beats;
    sq[1].push_back(8'h11);
    sq[1].push_back(8'h22);
    sq[1].push_back(8'h33);
    begin
      int n;
      n = 0;
      while (acc[1].size() < 3 && n < 30) begin
        cycle();
        n++;
      end
    end
    chk("flush_bytes_taken", 64'(acc[1].size()), 64'd3);
    repeat (14) cycle();
    chk("flush_not_early", 64'(beats - start), 64'd0);
    run_until(start + 1, 30, "flush_timeout");
    chk("flush_data", last_data, 64'h332211);
    chk("flush_nlanes", 64'(last_nl), 64'd3);
    chk("flush_dst", 64'(last_dst), 64'd1);
    chk("flush_latency", 64'(first_tv_cyc - last_acc_cyc), 64'd18);
`else
    // No flush: a stalled stream holds the packer until K lanes arrive
    start = beats;
    for (int i = 0; i < 3; i++) sq[1].push_back(8'($urandom));
    repeat (100) cycle();
    chk("noflush_no_beat", 64'(beats - start), 64'd0);
    chk("noflush_holds_fill", 64'(s_tready), 64'd2);
    for (int i = 0; i < 5; i++) sq[1].push_back(8'($urandom));
    run_until(start + 1, 50, "noflush_timeout");
    chk("noflush_nlanes", 64'(last_nl), 64'd8);
    chk("noflush_dst", 64'(last_dst), 64'd1);
`endif

    // Randomized traffic and backpressure
    for (int r = 0; r < 6; r++) begin
      tready_pct = $urandom_range(100, 30);
      total = 0;
      for (int g = 0; g < NOUT; g++) begin
        int nb;
        prob[g] = $urandom_range(100, 40);
        nb = K * $urandom_range(3, 0);
        for (int i = 0; i < nb; i++) sq[g].push_back(8'($urandom));
        total += nb;
      end
      run_until(beats + total / K, 2000, "rand_timeout");
      chk("rand_offer_drained", 64'(sq[0].size() + sq[1].size()), 64'd0);
      chk("rand_model_drained", 64'(acc[0].size() + acc[1].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
